// File: rtl/shared_tlb_req_arb_pkg.sv
// Shared types and widths for the ITLB/DTLB to shared-TLB request sequencer.
// Holds the FSM encoding, the source encoding and the latched request payload.
package shared_tlb_req_arb_pkg;

    localparam int VPN_WIDTH  = 20;
    localparam int ASID_WIDTH = 9;

    localparam logic SRC_INSTR = 1'b1;
    localparam logic SRC_DATA  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_RESP,
        ST_PTW_REQ,
        ST_PTW_WAIT
    } stlb_arb_state_e;

    typedef struct packed {
        logic [VPN_WIDTH-1:0]  vpn;
        logic [ASID_WIDTH-1:0] asid;
        logic                  is_instr;
    } stlb_req_t;

endpackage

// File: rtl/shared_tlb_req_arb_if.sv
// L1 miss, shared-TLB and page-table-walker signals seen by the request sequencer.
// master = the sequencer, slave = the surrounding L1 TLBs, shared TLB and walker.
interface shared_tlb_req_arb_if;
    import shared_tlb_req_arb_pkg::*;

    logic                  flush_i;
    logic [ASID_WIDTH-1:0] asid_i;
    logic                  itlb_miss_i;
    logic [VPN_WIDTH-1:0]  itlb_vpn_i;
    logic                  itlb_done_o;
    logic                  dtlb_miss_i;
    logic [VPN_WIDTH-1:0]  dtlb_vpn_i;
    logic                  dtlb_done_o;
    logic                  stlb_valid_o;
    logic                  stlb_ready_i;
    logic [VPN_WIDTH-1:0]  stlb_vpn_o;
    logic [ASID_WIDTH-1:0] stlb_asid_o;
    logic                  stlb_is_instr_o;
    logic                  stlb_resp_valid_i;
    logic                  stlb_hit_i;
    logic                  ptw_valid_o;
    logic                  ptw_ready_i;
    logic                  ptw_done_i;

    modport master (
        input  flush_i, asid_i, itlb_miss_i, itlb_vpn_i, dtlb_miss_i, dtlb_vpn_i,
        input  stlb_ready_i, stlb_resp_valid_i, stlb_hit_i, ptw_ready_i, ptw_done_i,
        output itlb_done_o, dtlb_done_o, stlb_valid_o, stlb_vpn_o, stlb_asid_o,
        output stlb_is_instr_o, ptw_valid_o
    );

    modport slave (
        output flush_i, asid_i, itlb_miss_i, itlb_vpn_i, dtlb_miss_i, dtlb_vpn_i,
        output stlb_ready_i, stlb_resp_valid_i, stlb_hit_i, ptw_ready_i, ptw_done_i,
        input  itlb_done_o, dtlb_done_o, stlb_valid_o, stlb_vpn_o, stlb_asid_o,
        input  stlb_is_instr_o, ptw_valid_o
    );

endinterface

// File: rtl/shared_tlb_req_arb_rr_arb_2.sv
// Two-way round-robin arbiter; grant is combinational, last_served updates when en_i accepts it.
// Latency 0; no backpressure of its own, the caller gates acceptance with en_i.
module rr_arb_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_vld_o,
    output logic       gnt_o
);
    logic last_q;

    assign gnt_vld_o = |req_i;
    assign gnt_o     = (req_i == 2'b11) ? ~last_q : req_i[1];

    // Reset to index 1 so that index 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (en_i && gnt_vld_o) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/shared_tlb_req_arb.sv
// Round-robin ITLB/DTLB miss sequencer: one shared-TLB lookup at a time, forwarded to the PTW on a miss.
// Hit path: grant N, lookup valid N+1, done pulse N+3; stalls in place on stlb_ready_i/ptw_ready_i low.
module shared_tlb_req_arb
    import shared_tlb_req_arb_pkg::*;
(
    input logic                  clk_i,
    input logic                  rst_i,
    shared_tlb_req_arb_if.master bus
);
    stlb_arb_state_e state_q, state_d;
    stlb_req_t       req_q, req_d;
    logic            squash_q, squash_d, squash_now;
    logic            itlb_done_q, itlb_done_d, dtlb_done_q, dtlb_done_d;
    logic            gnt_vld, gnt_instr, arb_en, src_miss, finish_ok;
    logic            stlb_valid, ptw_valid;

    assign arb_en = (state_q == ST_IDLE) && !bus.flush_i;

    rr_arb_2 u_rr_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     ({bus.itlb_miss_i, bus.dtlb_miss_i}),
        .en_i      (arb_en),
        .gnt_vld_o (gnt_vld),
        .gnt_o     (gnt_instr)
    );

    assign src_miss   = (req_q.is_instr == SRC_INSTR) ? bus.itlb_miss_i : bus.dtlb_miss_i;
    // A flush or a withdrawn miss squashes the request for the rest of its life.
    assign squash_now = squash_q || ((state_q != ST_IDLE) && (bus.flush_i || !src_miss));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            squash_q    <= 1'b0;
            itlb_done_q <= 1'b0;
            dtlb_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            squash_q    <= squash_d;
            itlb_done_q <= itlb_done_d;
            dtlb_done_q <= dtlb_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_en && gnt_vld) begin
                    state_d        = ST_LOOKUP;
                    req_d.vpn      = gnt_instr ? bus.itlb_vpn_i : bus.dtlb_vpn_i;
                    req_d.asid     = bus.asid_i;
                    req_d.is_instr = gnt_instr;
                end
            end
            ST_LOOKUP: begin
                if (bus.stlb_ready_i) state_d = ST_WAIT_RESP;
                else if (bus.flush_i) state_d = ST_IDLE;
            end
            ST_WAIT_RESP: begin
                // A squashed miss is not worth a walk: return straight to idle.
                if (bus.stlb_resp_valid_i) begin
                    state_d = (bus.stlb_hit_i || squash_now) ? ST_IDLE : ST_PTW_REQ;
                end
            end
            ST_PTW_REQ: begin
                if (bus.ptw_ready_i)  state_d = ST_PTW_WAIT;
                else if (bus.flush_i) state_d = ST_IDLE;
            end
            ST_PTW_WAIT: begin
                if (bus.ptw_done_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        squash_d = (state_d == ST_IDLE) ? 1'b0 : squash_now;
    end

    always_comb begin
        stlb_valid  = (state_q == ST_LOOKUP);
        ptw_valid   = (state_q == ST_PTW_REQ);
        finish_ok   = !squash_now &&
                      (((state_q == ST_WAIT_RESP) && bus.stlb_resp_valid_i && bus.stlb_hit_i) ||
                       ((state_q == ST_PTW_WAIT) && bus.ptw_done_i));
        itlb_done_d = finish_ok && (req_q.is_instr == SRC_INSTR);
        dtlb_done_d = finish_ok && (req_q.is_instr == SRC_DATA);
    end

    assign bus.stlb_valid_o    = stlb_valid;
    assign bus.ptw_valid_o     = ptw_valid;
    assign bus.stlb_vpn_o      = req_q.vpn;
    assign bus.stlb_asid_o     = req_q.asid;
    assign bus.stlb_is_instr_o = req_q.is_instr;
    assign bus.itlb_done_o     = itlb_done_q;
    assign bus.dtlb_done_o     = dtlb_done_q;

endmodule

// File: doc/shared_tlb_req_arb.md
# shared_tlb_req_arb

Sequencing controller for the shared second-level TLB used when the instruction and data first-level TLBs (2 entries each) back onto one shared TLB (64 entries). It arbitrates ITLB and DTLB miss requests round-robin and drives exactly one shared-TLB lookup at a time. On a shared-TLB miss it forwards the lookup to the page-table walker and reports completion to the originating requester. It sits between the two L1 TLBs and the shared TLB/PTW pair inside the MMU.

## Interface
- VPN_WIDTH, 20, virtual page number width (Sv32)
- ASID_WIDTH, 9, address-space identifier width
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  sfence/flush; abort or squash the in-flight request
- asid_i  in  ASID_WIDTH  current ASID, sampled at grant
- itlb_miss_i  in  1  ITLB miss pending (level, held until done or withdrawn)
- itlb_vpn_i  in  VPN_WIDTH  ITLB miss VPN
- itlb_done_o  out  1  one-cycle pulse: ITLB request resolved
- dtlb_miss_i  in  1  DTLB miss pending
- dtlb_vpn_i  in  VPN_WIDTH  DTLB miss VPN
- dtlb_done_o  out  1  one-cycle pulse: DTLB request resolved
- stlb_valid_o  out  1  lookup request to shared TLB
- stlb_ready_i  in  1  shared TLB accepts lookup
- stlb_vpn_o  out  VPN_WIDTH  latched VPN
- stlb_asid_o  out  ASID_WIDTH  latched ASID
- stlb_is_instr_o  out  1  latched source (1 = ITLB)
- stlb_resp_valid_i  in  1  lookup result valid
- stlb_hit_i  in  1  lookup hit (qualified by resp_valid)
- ptw_valid_o  out  1  walk request
- ptw_ready_i  in  1  PTW accepts walk
- ptw_done_i  in  1  walk finished (refill or fault written back)

## Operation
- FSM states: IDLE, LOOKUP, WAIT_RESP, PTW_REQ, PTW_WAIT.
- IDLE: if any miss_i, grant; latch vpn, asid, source; -> LOOKUP. None -> stay.
- Arbitration: round-robin via 1-bit last_served; both pending -> grant the one not last served; single pending -> grant it. Reset last_served = instr, so DTLB wins the first tie. last_served updates at grant.
- LOOKUP: stlb_valid_o=1 with stable payload; handshake (valid&ready) -> WAIT_RESP.
- WAIT_RESP: resp_valid&hit -> done pulse to source, -> IDLE. resp_valid&!hit -> PTW_REQ.
- PTW_REQ: ptw_valid_o=1; ptw_ready_i -> PTW_WAIT.
- PTW_WAIT: ptw_done_i -> done pulse, -> IDLE.
- Squash flag: set by flush_i in WAIT_RESP/PTW_REQ/PTW_WAIT, or by source miss_i deasserting while granted. Squashed request still completes its transaction but emits no done pulse. Flag cleared on return to IDLE.
- flush_i in IDLE: no grant that cycle. flush_i in LOOKUP before handshake: drop valid, -> IDLE next cycle (no transaction issued). flush_i in PTW_REQ before ready: -> IDLE, no walk issued.
- Outputs not in their state drive 0 (valid/done); payload holds last latched value.
- Reset mid-operation: FSM -> IDLE immediately; no done pulse; response/ptw_done arriving after reset are ignored.

## Timing
- Reset values: all valid/done outputs 0, payload 0, state IDLE, last_served = instr, squash 0.
- Grant to stlb_valid_o: 1 cycle (registered). Hit path minimum: grant cycle N, valid N+1, resp N+2, done pulse N+3 (registered), IDLE N+3; next grant N+3.
- done pulses are registered, exactly one cycle, never both in one cycle.
- Starvation bound: a pending requester is granted within one other transaction.
- Simultaneous resp_valid and flush_i in WAIT_RESP: squash wins, no done, no PTW request.

## Structure
- Put the state enum (stlb_arb_state_e) and source encoding constants in the MMU shared package; VPN/ASID widths come from the config-derived values there.
- Single module; optional sub-module rr_arb_2 (2-way round-robin with last_served register) for reuse.

## Test plan
- Both misses at reset release, dtlb_vpn=0x12345, itlb_vpn=0x0ABCD -> first stlb_vpn_o=0x12345 is_instr=0; after hit, second lookup 0x0ABCD is_instr=1.
- DTLB miss, stlb_ready_i=0 for 3 cycles -> stlb_valid_o held 4 cycles, payload stable; hit -> dtlb_done_o one pulse, itlb_done_o 0.
- ITLB miss, shared miss -> ptw_valid_o until ready; ptw_done_i after 10 cycles -> itlb_done_o pulse next cycle.
- flush_i during PTW_WAIT -> walk completes, no done pulse, FSM IDLE after ptw_done_i, next pending miss granted.
- flush_i in LOOKUP with stlb_ready_i=0 -> stlb_valid_o drops next cycle, no response awaited, no done.
- rst_i asserted in WAIT_RESP -> all outputs 0 next cycle; later stlb_resp_valid_i ignored.
